instr_mem_loader: RTL and testbench

//  Sits directly downstream of the bios stage. Consumes the per-clock instruction word

---
 rtl/instr_mem_loader.sv | 68 ++++++
 tb/tb_instr_mem_loader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Boot loader: copies the bios word stream into instruction memory from BASE_ADDR, holds the CPU until done.
// Write latency 1 cycle; no backpressure: the bios cannot be stalled, so words beyond memory depth are dropped.
module instr_mem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] bios_data,
  input  logic                  bios_active,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  cpu_start,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  overflow
);

  typedef enum logic [1:0] {IDLE, LOAD, FINISH, RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= BASE;
      mem_wdata  <= '0;
      load_count <= '0;
      cpu_hold   <= 1'b1;
      cpu_start  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      cpu_start <= 1'b0;
      case (state)
        IDLE: begin
          // first active cycle only primes the bios; its data is not a program word
          if (bios_active) state <= LOAD;
        end
        LOAD: begin
          if (!bios_active) begin
            state     <= FINISH;
            cpu_start <= 1'b1;
            cpu_hold  <= 1'b0;
          end else if (load_count < DEPTH) begin
            mem_we     <= 1'b1;
            mem_addr   <= BASE + load_count[ADDR_WIDTH-1:0];
            mem_wdata  <= bios_data;
            load_count <= load_count + ONE;
          end else begin
            overflow <= 1'b1;
          end
        end
        FINISH:  state <= RUN;
        RUN:     state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Drives one bios stream into three loader configurations; a per-instance queue of expected writes
// is filled as words are driven and drained as mem_we pulses appear.
module tb_instr_mem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] bios_data = '0;
  logic        bios_active = 1'b0;

  always #5 clock = ~clock;

  // A: defaults, B: BASE_ADDR=0xFE, C: ADDR_WIDTH=2
  logic        a_we, a_hold, a_start, a_ovf;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic [8:0]  a_cnt;
  logic        b_we, b_hold, b_start, b_ovf;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata;
  logic [8:0]  b_cnt;
  logic        c_we, c_hold, c_start, c_ovf;
  logic [1:0]  c_addr;
  logic [31:0] c_wdata;
  logic [2:0]  c_cnt;

  instr_mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .BASE_ADDR(0)) u_a (
    .clock(clock), .reset(reset), .bios_data(bios_data), .bios_active(bios_active),
    .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata), .cpu_hold(a_hold),
    .cpu_start(a_start), .load_count(a_cnt), .overflow(a_ovf));

  instr_mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .BASE_ADDR(254)) u_b (
    .clock(clock), .reset(reset), .bios_data(bios_data), .bios_active(bios_active),
    .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata), .cpu_hold(b_hold),
    .cpu_start(b_start), .load_count(b_cnt), .overflow(b_ovf));

  instr_mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .BASE_ADDR(0)) u_c (
    .clock(clock), .reset(reset), .bios_data(bios_data), .bios_active(bios_active),
    .mem_we(c_we), .mem_addr(c_addr), .mem_wdata(c_wdata), .cpu_hold(c_hold),
    .cpu_start(c_start), .load_count(c_cnt), .overflow(c_ovf));

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];
  wr_t qc[$];
  int  sa = 0, sb = 0, sc = 0;
  int  n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin : mon_a
    wr_t w;
    if (a_we) begin
      check("A_we_expected", qa.size() > 0, 1);
      if (qa.size() > 0) begin
        w = qa.pop_front();
        check("A_addr", a_addr, w.addr);
        check("A_wdata", a_wdata, w.data);
      end
    end
    if (a_start) begin
      sa++;
      check("A_start_after_writes", qa.size(), 0);
    end
  end

  always @(negedge clock) begin : mon_b
    wr_t w;
    if (b_we) begin
      check("B_we_expected", qb.size() > 0, 1);
      if (qb.size() > 0) begin
        w = qb.pop_front();
        check("B_addr", b_addr, w.addr);
        check("B_wdata", b_wdata, w.data);
      end
    end
    if (b_start) begin
      sb++;
      check("B_start_after_writes", qb.size(), 0);
    end
  end

  always @(negedge clock) begin : mon_c
    wr_t w;
    if (c_we) begin
      check("C_we_expected", qc.size() > 0, 1);
      if (qc.size() > 0) begin
        w = qc.pop_front();
        check("C_addr", c_addr, w.addr);
        check("C_wdata", c_wdata, w.data);
      end
    end
    if (c_start) begin
      sc++;
      check("C_start_after_writes", qc.size(), 0);
    end
  end

  task automatic push_word(input int i, input logic [31:0] d);
    wr_t w;
    w.data = d;
    if (i < 256) begin
      w.addr = i % 256;
      qa.push_back(w);
      w.addr = (254 + i) % 256;
      qb.push_back(w);
    end
    if (i < 4) begin
      w.addr = i % 4;
      qc.push_back(w);
    end
  endtask

  // Reset for two edges (optionally with bios still active) and verify the reset state.
  task automatic do_reset(input logic act);
    @(negedge clock);
    reset       = 1'b1;
    bios_active = act;
    bios_data   = $urandom;
    repeat (2) @(negedge clock);
    qa.delete(); qb.delete(); qc.delete();
    sa = 0; sb = 0; sc = 0;
    check("A_rst_we", a_we, 0);       check("A_rst_addr", a_addr, 0);
    check("A_rst_wdata", a_wdata, 0); check("A_rst_cnt", a_cnt, 0);
    check("A_rst_hold", a_hold, 1);   check("A_rst_start", a_start, 0);
    check("A_rst_ovf", a_ovf, 0);
    check("B_rst_addr", b_addr, 8'hFE); check("B_rst_cnt", b_cnt, 0);
    check("B_rst_hold", b_hold, 1);
    check("C_rst_addr", c_addr, 0);   check("C_rst_cnt", c_cnt, 0);
    check("C_rst_ovf", c_ovf, 0);     check("C_rst_hold", c_hold, 1);
    reset       = 1'b0;
    bios_active = 1'b0;
  endtask

  task automatic run_prog(input int n, input logic [31:0] pat, input bit wiggle);
    logic [31:0] d;
    @(negedge clock);
    bios_active = 1'b1;
    bios_data   = 32'hDEAD_0000 | 32'($urandom_range(0, 255));
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      d = pat + 32'(i);
      bios_data   = d;
      bios_active = 1'b1;
      push_word(i, d);
    end
    @(negedge clock);
    bios_active = 1'b0;
    bios_data   = 32'hBAD0_BAD0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (wiggle) begin
        bios_active = 1'($urandom_range(0, 1));
        bios_data   = $urandom;
      end
    end
    @(negedge clock);
    bios_active = 1'b0;
    @(negedge clock);
    check("A_queue_drained", qa.size(), 0);
    check("A_cnt", a_cnt, (n < 256) ? n : 256);
    check("A_ovf", a_ovf, n > 256);
    check("A_starts", sa, 1);
    check("A_hold", a_hold, 0);
    check("B_queue_drained", qb.size(), 0);
    check("B_cnt", b_cnt, (n < 256) ? n : 256);
    check("B_starts", sb, 1);
    check("B_hold", b_hold, 0);
    check("C_queue_drained", qc.size(), 0);
    check("C_cnt", c_cnt, (n < 4) ? n : 4);
    check("C_ovf", c_ovf, n > 4);
    check("C_starts", sc, 1);
    check("C_hold", c_hold, 0);
  endtask

  initial begin
    // four-word program, then bios wiggling while in RUN
    do_reset(1'b0);
    run_prog(4, 32'h0000_00A0, 1'b1);
    // three words: B wraps 0xFE, 0xFF, 0x00
    do_reset(1'b0);
    run_prog(3, 32'h0000_0100, 1'b0);
    // six words: C keeps four and flags overflow
    do_reset(1'b0);
    run_prog(6, 32'h0000_0200, 1'b1);
    // reset lands after two words of a five-word load, then reload
    do_reset(1'b0);
    @(negedge clock);
    bios_active = 1'b1;
    bios_data   = $urandom;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      bios_data = 32'h0000_0300 + 32'(i);
      push_word(i, bios_data);
    end
    do_reset(1'b1);
    run_prog(5, 32'h0000_0400, 1'b0);
    // empty program
    do_reset(1'b0);
    run_prog(0, 32'h0, 1'b1);
    // memory exactly full, then one word too many
    do_reset(1'b0);
    run_prog(256, 32'h0001_0000, 1'b0);
    do_reset(1'b0);
    run_prog(257, 32'h0002_0000, 1'b0);
    // bios never starts: CPU held indefinitely
    do_reset(1'b0);
    repeat (12) begin
      @(negedge clock);
      bios_data = $urandom;
    end
    check("idle_A_hold", a_hold, 1);
    check("idle_C_hold", c_hold, 1);
    check("idle_starts", sa + sb + sc, 0);
    check("idle_A_cnt", a_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
